// File: rtl/div_req_ctrl.sv
// div_req_ctrl
// Request-side controller for the fixed-point divider wrapper. Accepts tagged
// Q12.12 divide requests, issues the operands to the divider, matches each
// in-order divider result back to its tag and buffers the result until the
// consumer takes it. A zero divisor is flagged here and the quotient replaced
// by a saturated value, so the divider never needs a special case for it.
//
// Ports
//   i_clk, i_rst            single clock, synchronous active-high reset
//   i_req_*/o_req_ready     tagged request in (dividend, divisor, tag)
//   o_div_*                 registered operands + tvalid to the divider
//   i_div_tvalid/result     divider quotient, one-cycle pulse, no backpressure
//   o_rsp_*/i_rsp_ready     show-ahead response out (result, tag, div0 flag)
//   o_pending               requests accepted but not yet consumed
//   o_err_orphan            sticky: divider result arrived with no tag waiting
module div_req_ctrl #(
  parameter int TAG_W = 8,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [23:0]            i_req_dividend,
  input  logic [23:0]            i_req_divisor,
  input  logic [TAG_W-1:0]       i_req_tag,
  output logic                   o_div_dividend_tvalid,
  output logic [23:0]            o_div_dividend,
  output logic                   o_div_divisor_tvalid,
  output logic [23:0]            o_div_divisor,
  input  logic                   i_div_tvalid,
  input  logic [23:0]            i_div_result,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [23:0]            o_rsp_result,
  output logic [TAG_W-1:0]       o_rsp_tag,
  output logic                   o_rsp_div0,
  output logic [$clog2(DEPTH):0] o_pending,
  output logic                   o_err_orphan
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [23:0] SAT_POS = 24'h7FFFFF;
  localparam logic [23:0] SAT_NEG = 24'h800000;

  logic [PW-1:0]      r_pending;
  logic               r_err_orphan;
  logic               r_issue;
  logic [23:0]        r_dividend;
  logic [23:0]        r_divisor;

  // tag FIFO entry: {tag, div0, dividend sign}
  logic [TAG_W+1:0]   r_tag_mem [DEPTH];
  logic [AW-1:0]      r_tag_wr;
  logic [AW-1:0]      r_tag_rd;
  logic [PW-1:0]      r_tag_cnt;

  // result FIFO entry: {result, tag, div0}
  logic [TAG_W+24:0]  r_res_mem [DEPTH];
  logic [AW-1:0]      r_res_wr;
  logic [AW-1:0]      r_res_rd;
  logic [PW-1:0]      r_res_cnt;

  logic               w_accept;
  logic               w_consume;
  logic               w_req_div0;
  logic               w_tag_empty;
  logic               w_tag_pop;
  logic               w_orphan;
  logic [TAG_W+1:0]   w_tag_head;
  logic [23:0]        w_res_value;
  logic [TAG_W+24:0]  w_res_head;

  // Credit is derived from the registered count only, never from i_req_valid.
  assign o_req_ready = !i_rst && (r_pending < DEPTH_P);
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_req_div0  = (i_req_divisor == 24'd0);

  assign w_tag_empty = (r_tag_cnt == '0);
  assign w_tag_pop   = i_div_tvalid && !w_tag_empty;
  assign w_orphan    = i_div_tvalid && w_tag_empty;
  assign w_tag_head  = r_tag_mem[r_tag_rd];

  always_comb begin
    w_res_value = i_div_result;
    if (w_tag_head[1]) begin
      w_res_value = w_tag_head[0] ? SAT_NEG : SAT_POS;
    end
  end

  assign o_rsp_valid = (r_res_cnt != '0);
  assign w_consume   = o_rsp_valid && i_rsp_ready;
  assign w_res_head  = r_res_mem[r_res_rd];
  // Head fields are masked while empty so the outputs read zero after reset.
  assign o_rsp_result = o_rsp_valid ? w_res_head[TAG_W+24:TAG_W+1] : 24'd0;
  assign o_rsp_tag    = o_rsp_valid ? w_res_head[TAG_W:1] : '0;
  assign o_rsp_div0   = o_rsp_valid && w_res_head[0];

  assign o_div_dividend_tvalid = r_issue;
  assign o_div_divisor_tvalid  = r_issue;
  assign o_div_dividend        = r_dividend;
  assign o_div_divisor         = r_divisor;
  assign o_pending             = r_pending;
  assign o_err_orphan          = r_err_orphan;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending    <= '0;
      r_err_orphan <= 1'b0;
      r_issue      <= 1'b0;
      r_dividend   <= 24'd0;
      r_divisor    <= 24'd0;
      r_tag_wr     <= '0;
      r_tag_rd     <= '0;
      r_tag_cnt    <= '0;
      r_res_wr     <= '0;
      r_res_rd     <= '0;
      r_res_cnt    <= '0;
    end else begin
      r_issue <= w_accept;
      if (w_accept) begin
        r_dividend <= i_req_dividend;
        r_divisor  <= i_req_divisor;
        r_tag_wr   <= r_tag_wr + 1'b1;
      end
      case ({w_accept, w_consume})
        2'b10:   r_pending <= r_pending + 1'b1;
        2'b01:   r_pending <= r_pending - 1'b1;
        default: r_pending <= r_pending;
      endcase
      if (w_orphan) begin
        r_err_orphan <= 1'b1;
      end
      if (w_tag_pop) begin
        r_tag_rd <= r_tag_rd + 1'b1;
        r_res_wr <= r_res_wr + 1'b1;
      end
      if (w_consume) begin
        r_res_rd <= r_res_rd + 1'b1;
      end
      r_tag_cnt <= r_tag_cnt + PW'(w_accept) - PW'(w_tag_pop);
      r_res_cnt <= r_res_cnt + PW'(w_tag_pop) - PW'(w_consume);
    end
  end

  // Storage carries no reset; occupancy is governed by the counts above.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_tag_mem[r_tag_wr] <= {i_req_tag, w_req_div0, i_req_dividend[23]};
    end
    if (w_tag_pop && !i_rst) begin
      r_res_mem[r_res_wr] <= {w_res_value, w_tag_head[TAG_W+1:2], w_tag_head[1]};
    end
  end

endmodule

// File: tb/tb_div_req_ctrl.sv
// Bench for div_req_ctrl: a fixed-latency divider model feeds results back,
// and a queue-based reference (one entry per accepted request, in order)
// predicts every output on every cycle.
module tb_div_req_ctrl;
  localparam int DEPTH = 16;
  localparam int TAG_W = 8;
  localparam int DL    = 4;

  logic             clk = 1'b0;
  always #5 clk = ~clk;

  logic             i_rst;
  logic             i_req_valid;
  logic             o_req_ready;
  logic [23:0]      i_req_dividend;
  logic [23:0]      i_req_divisor;
  logic [TAG_W-1:0] i_req_tag;
  logic             o_div_dividend_tvalid;
  logic [23:0]      o_div_dividend;
  logic             o_div_divisor_tvalid;
  logic [23:0]      o_div_divisor;
  logic             i_div_tvalid;
  logic [23:0]      i_div_result;
  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic [23:0]      o_rsp_result;
  logic [TAG_W-1:0] o_rsp_tag;
  logic             o_rsp_div0;
  logic [4:0]       o_pending;
  logic             o_err_orphan;

  div_req_ctrl #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .i_clk                 (clk),
    .i_rst                 (i_rst),
    .i_req_valid           (i_req_valid),
    .o_req_ready           (o_req_ready),
    .i_req_dividend        (i_req_dividend),
    .i_req_divisor         (i_req_divisor),
    .i_req_tag             (i_req_tag),
    .o_div_dividend_tvalid (o_div_dividend_tvalid),
    .o_div_dividend        (o_div_dividend),
    .o_div_divisor_tvalid  (o_div_divisor_tvalid),
    .o_div_divisor         (o_div_divisor),
    .i_div_tvalid          (i_div_tvalid),
    .i_div_result          (i_div_result),
    .o_rsp_valid           (o_rsp_valid),
    .i_rsp_ready           (i_rsp_ready),
    .o_rsp_result          (o_rsp_result),
    .o_rsp_tag             (o_rsp_tag),
    .o_rsp_div0            (o_rsp_div0),
    .o_pending             (o_pending),
    .o_err_orphan          (o_err_orphan)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Signed Q12.12 quotient, truncated toward zero, low 24 bits kept.
  function automatic logic [23:0] qdiv(input logic [23:0] a, input logic [23:0] b);
    longint na, nb, q;
    na = longint'($signed(a)) * 64'sd4096;
    nb = longint'($signed(b));
    if (nb == 0) return 24'hA5A5A5;
    q = na / nb;
    return q[23:0];
  endfunction

  function automatic logic [23:0] exp_result(input logic [23:0] a, input logic [23:0] b);
    if (b == 24'd0) return a[23] ? 24'h800000 : 24'h7FFFFF;
    return qdiv(a, b);
  endfunction

  // Divider model: fixed latency DL, keeps running across the DUT reset.
  logic        dpipe_v [DL];
  logic [23:0] dpipe_q [DL];
  initial begin
    i_div_tvalid = 1'b0;
    i_div_result = 24'd0;
    for (int k = 0; k < DL; k++) begin
      dpipe_v[k] = 1'b0;
      dpipe_q[k] = 24'd0;
    end
    forever begin
      @(posedge clk);
      #2;
      i_div_tvalid = dpipe_v[DL-1];
      i_div_result = dpipe_v[DL-1] ? dpipe_q[DL-1] : 24'($urandom);
      for (int k = DL - 1; k > 0; k--) begin
        dpipe_v[k] = dpipe_v[k-1];
        dpipe_q[k] = dpipe_q[k-1];
      end
      dpipe_v[0] = (o_div_dividend_tvalid === 1'b1) && (o_div_divisor_tvalid === 1'b1);
      dpipe_q[0] = qdiv(o_div_dividend, o_div_divisor);
    end
  end

  // Reference: requests in acceptance order; 'back' marks a returned result.
  typedef struct {
    logic [7:0]  tag;
    logic [23:0] res;
    logic        div0;
    bit          back;
  } ent_t;

  ent_t        mq[$];
  bit          m_live   = 1'b0;
  bit          m_orphan = 1'b0;
  bit          m_iss    = 1'b0;
  logic [23:0] m_a      = 24'd0;
  logic [23:0] m_b      = 24'd0;
  int          cyc      = 0;
  int          n_cons   = 0;
  int          first_cons = -1;
  int          last_cons  = -1;
  bit          rec_tags = 1'b0;
  logic [7:0]  seen[$];

  always @(negedge clk) begin
    bit exp_v;
    bit acc;
    bit cons;
    int idx;
    exp_v = (mq.size() > 0) && mq[0].back;
    if (m_live) begin
      chk("pending", 32'(o_pending), 32'(mq.size()));
      chk("req_ready", 32'(o_req_ready), 32'(!i_rst && (mq.size() < DEPTH)));
      chk("err_orphan", 32'(o_err_orphan), 32'(m_orphan));
      chk("rsp_valid", 32'(o_rsp_valid), 32'(exp_v));
      chk("dividend_tvalid", 32'(o_div_dividend_tvalid), 32'(m_iss));
      chk("divisor_tvalid", 32'(o_div_divisor_tvalid), 32'(m_iss));
      chk("div_dividend", 32'(o_div_dividend), 32'(m_a));
      chk("div_divisor", 32'(o_div_divisor), 32'(m_b));
      if (exp_v) begin
        chk("rsp_result", 32'(o_rsp_result), 32'(mq[0].res));
        chk("rsp_tag", 32'(o_rsp_tag), 32'(mq[0].tag));
        chk("rsp_div0", 32'(o_rsp_div0), 32'(mq[0].div0));
      end
    end
    // advance the reference across the coming rising edge
    if (i_rst) begin
      mq.delete();
      m_orphan = 1'b0;
      m_iss    = 1'b0;
      m_a      = 24'd0;
      m_b      = 24'd0;
      m_live   = 1'b1;
    end else if (m_live) begin
      acc  = i_req_valid && (mq.size() < DEPTH);
      cons = exp_v && i_rsp_ready;
      if (i_div_tvalid) begin
        idx = -1;
        for (int k = 0; k < mq.size(); k++) begin
          if (!mq[k].back) begin
            idx = k;
            break;
          end
        end
        if (idx < 0) m_orphan = 1'b1;
        else mq[idx].back = 1'b1;
      end
      if (cons) begin
        if (rec_tags) seen.push_back(mq[0].tag);
        n_cons++;
        if (first_cons < 0) first_cons = cyc + 1;
        last_cons = cyc + 1;
        void'(mq.pop_front());
      end
      m_iss = acc;
      if (acc) begin
        m_a = i_req_dividend;
        m_b = i_req_divisor;
        mq.push_back('{i_req_tag, exp_result(i_req_dividend, i_req_divisor),
                       (i_req_divisor == 24'd0), 1'b0});
      end
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one request and hold it until accepted; returns cycles spent.
  task automatic send(input logic [7:0] tag, input logic [23:0] a, input logic [23:0] b,
                      output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    i_req_valid = 1'b1;
    i_req_tag = tag;
    i_req_dividend = a;
    i_req_divisor = b;
    while (!ok && waits < 300) begin
      @(negedge clk);
      ok = (o_req_ready === 1'b1);
      @(posedge clk);
      #1;
      waits++;
    end
    i_req_valid = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int k;
    int wsum;
    int c0;
    logic [23:0] a;
    logic [23:0] b;
    i_rst = 1'b1;
    i_req_valid = 1'b0;
    i_req_dividend = 24'd0;
    i_req_divisor = 24'd0;
    i_req_tag = 8'd0;
    i_rsp_ready = 1'b0;
    tick(3);
    i_rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 32'(o_req_ready), 32'd1);
    chk("post_reset_result", 32'(o_rsp_result), 32'd0);
    chk("post_reset_tag", 32'(o_rsp_tag), 32'd0);
    chk("post_reset_div0", 32'(o_rsp_div0), 32'd0);

    // single request: 100.0 / 4.0
    tick(1);
    send(8'h5A, 24'h064000, 24'h004000, w);
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (o_rsp_valid === 1'b1) break;
      @(posedge clk);
      #1;
      k++;
    end
    // visible after edge N+L+1, i.e. in cycle N+L+2
    chk("single_latency", 32'(k), 32'(DL + 1));
    chk("single_result", 32'(o_rsp_result), 32'h019000);
    chk("single_tag", 32'(o_rsp_tag), 32'h5A);
    chk("single_div0", 32'(o_rsp_div0), 32'd0);
    tick(1);
    i_rsp_ready = 1'b1;
    tick(1);
    i_rsp_ready = 1'b0;

    // divide by zero, both signs
    send(8'h11, 24'hFFD000, 24'd0, w);
    send(8'h12, 24'h001000, 24'd0, w);
    tick(DL + 4);
    @(negedge clk);
    chk("div0_neg_result", 32'(o_rsp_result), 32'h800000);
    chk("div0_neg_flag", 32'(o_rsp_div0), 32'd1);
    tick(1);
    i_rsp_ready = 1'b1;
    tick(1);
    i_rsp_ready = 1'b0;
    @(negedge clk);
    chk("div0_pos_result", 32'(o_rsp_result), 32'h7FFFFF);
    chk("div0_pos_flag", 32'(o_rsp_div0), 32'd1);
    tick(1);
    i_rsp_ready = 1'b1;
    tick(1);
    i_rsp_ready = 1'b0;

    // backpressure: 20 offered, 16 fit
    for (int t = 0; t < 16; t++) begin
      send(8'(t), 24'(t) << 14, (24'(t) + 24'd1) << 10, w);
    end
    i_req_valid = 1'b1;
    i_req_tag = 8'd16;
    i_req_dividend = 24'h040000;
    i_req_divisor = 24'h002000;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("full_ready", 32'(o_req_ready), 32'd0);
      chk("full_pending", 32'(o_pending), 32'd16);
      @(posedge clk);
      #1;
    end
    chk("full_orphan", 32'(o_err_orphan), 32'd0);
    seen.delete();
    rec_tags = 1'b1;
    i_rsp_ready = 1'b1;
    for (int t = 16; t < 20; t++) begin
      send(8'(t), 24'(t) << 14, 24'h002000, w);
    end
    tick(40);
    rec_tags = 1'b0;
    chk("bp_count", 32'(seen.size()), 32'd20);
    for (int t = 0; t < 20 && t < seen.size(); t++) begin
      chk("bp_order", 32'(seen[t]), 32'(t));
    end

    // simultaneous accept and response at pending 15
    i_rsp_ready = 1'b0;
    for (int t = 0; t < 15; t++) begin
      send(8'($urandom), 24'($urandom), 24'($urandom_range(1, 24'hFFFFFF)), w);
    end
    tick(DL + 4);
    i_req_valid = 1'b1;
    i_req_tag = 8'hEE;
    i_req_dividend = 24'h003000;
    i_req_divisor = 24'h001000;
    i_rsp_ready = 1'b1;
    @(negedge clk);
    chk("pre_both_pending", 32'(o_pending), 32'd15);
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b0;
    @(negedge clk);
    chk("both_pending", 32'(o_pending), 32'd15);
    tick(1);
    i_rsp_ready = 1'b1;
    tick(30);

    // 64 back-to-back requests
    c0 = n_cons;
    first_cons = -1;
    wsum = 0;
    for (int t = 0; t < 64; t++) begin
      a = 24'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom);
      send(8'(t + 100), a, b, w);
      wsum += w;
    end
    tick(DL + 10);
    chk("stream_accept_cycles", 32'(wsum), 32'd64);
    chk("stream_rsp_count", 32'(n_cons - c0), 32'd64);
    chk("stream_rsp_span", 32'(last_cons - first_cons), 32'd63);

    // random traffic: heavy backpressure first, then light
    for (int t = 0; t < 400; t++) begin
      i_req_valid = ($urandom_range(0, 3) != 0);
      i_req_tag = 8'($urandom);
      i_req_dividend = 24'($urandom);
      i_req_divisor = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom);
      i_rsp_ready = ($urandom_range(0, 3) < ((t < 200) ? 1 : 3));
      tick(1);
    end
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    tick(40);

    // reset with 5 requests in flight
    i_rsp_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      send(8'(t + 50), 24'(t + 1) << 12, 24'h001000, w);
    end
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    @(negedge clk);
    chk("rst_pending", 32'(o_pending), 32'd0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(o_rsp_result), 32'd0);
    chk("rst_rsp_tag", 32'(o_rsp_tag), 32'd0);
    chk("rst_tvalid", 32'(o_div_dividend_tvalid), 32'd0);
    chk("rst_orphan", 32'(o_err_orphan), 32'd0);
    tick(DL + 4);
    @(negedge clk);
    chk("stale_orphan", 32'(o_err_orphan), 32'd1);
    chk("stale_rsp_valid", 32'(o_rsp_valid), 32'd0);
    tick(1);
    c0 = n_cons;
    i_rsp_ready = 1'b1;
    send(8'hC3, 24'hFF8000, 24'h002000, w);
    tick(DL + 6);
    chk("after_rst_rsp", 32'(n_cons - c0), 32'd1);
    chk("orphan_sticky", 32'(o_err_orphan), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_req_ctrl.md
# div_req_ctrl

Request-side controller for the fixed-point divider wrapper. It accepts tagged divide requests from the ray-tracing datapath and drives the divider's dividend/divisor AXI-stream inputs. It matches each in-order divider result back to its tag and buffers results so that downstream stalls never lose a quotient. Divide-by-zero is flagged and saturated here. The divider itself is never asked to handle it specially.

## Interface
- `TAG_W`, default 8: request tag width.
- `DEPTH`, default 16: power of 2, ≥2. Maximum requests pending, counted as in-flight plus buffered. This is also the depth of the tag FIFO and of the result FIFO.
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous reset, active-high.
- `req_valid`, in, 1: request valid.
- `req_ready`, out, 1: request ready.
- `req_dividend`, in, 24: signed Q12.12.
- `req_divisor`, in, 24: signed Q12.12.
- `req_tag`, in, `TAG_W`: opaque tag, returned with the result.
- `div_dividend_tvalid`, out, 1: to the divider; asserted together with `div_divisor_tvalid`.
- `div_dividend`, out, 24: registered operand.
- `div_divisor_tvalid`, out, 1: to the divider.
- `div_divisor`, out, 24: registered operand.
- `div_tvalid`, in, 1: divider result valid. This is a one-cycle pulse with no backpressure.
- `div_result`, in, 24: signed Q12.12 quotient.
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: response ready.
- `rsp_result`, out, 24: signed Q12.12 quotient, or the saturated value.
- `rsp_tag`, out, `TAG_W`: tag of the request.
- `rsp_div0`, out, 1: the request had divisor == 0.
- `pending`, out, clog2(`DEPTH`)+1: requests accepted but not yet consumed.
- `err_orphan`, out, 1: sticky. Set when `div_tvalid` arrives while the tag FIFO is empty.

## Operation
- **Credit rule.** `req_ready = (pending < DEPTH)`. It is combinational from registered `pending` and does not depend on `req_valid`.
- **Accept.** On `req_valid && req_ready`:
  - register the operands into `div_dividend` and `div_divisor`;
  - push {tag, div0 = (divisor == 0), dividend sign} into the tag FIFO.
- **Issue.** `div_*_tvalid` are high on the cycle after acceptance, for exactly one cycle per accepted request. Back-to-back accepts give continuous tvalid.
- **Return.** On `div_tvalid`, pop the tag FIFO and push {result, tag, div0} into the result FIFO.
  - If div0 is clear, result = `div_result`.
  - If div0 is set and the dividend is ≥0, result = 24'h7FFFFF. If the dividend is <0, result = 24'h800000.
- **Pending counter.**
  - +1 on accept.
  - −1 on `rsp_valid && rsp_ready`.
  - Unchanged when both happen in the same cycle.
  - Never exceeds `DEPTH`, so neither FIFO can overflow while the divider returns exactly one result per issue.
- **Orphan result.** `div_tvalid` with the tag FIFO empty is dropped, no result is written, and `err_orphan` is set. It stays set until `rst`.
- **Response output.** The result FIFO is show-ahead: `rsp_valid = !empty`, and `rsp_*` show the head entry. Responses are in strict acceptance order.
- **Reset.** `rst` clears both FIFOs, `pending`, and `err_orphan`, and drops all in-flight work. Reset values:
  - `div_*_tvalid` = 0;
  - `div_dividend` = 0 and `div_divisor` = 0;
  - `rsp_valid` = 0 and `rsp_result` = 0, `rsp_tag` = 0, `rsp_div0` = 0;
  - `pending` = 0 and `err_orphan` = 0;
  - `req_ready` = 0 while `rst` is high, and 1 on the first cycle after.
- **Divider results after reset.** Results that were in flight in the divider when reset was applied arrive as orphans and set `err_orphan`. The system must reset or drain the divider alongside this block.

## Timing
- Accept at edge N → `div_*_tvalid` high during cycle N+1.
- `div_tvalid` sampled at edge M → `rsp_valid` high from cycle M+1, with the entry at the FIFO head.
- End-to-end latency: divider latency L + 2 cycles.
- Throughput: 1 request per cycle sustained when `rsp_ready` is held high.
- Full boundary: at `pending == DEPTH`, `req_ready` = 0. An accept and a response in the same cycle are only possible below `DEPTH`. A response consumed at `DEPTH` raises `req_ready` on the next cycle.
- Simultaneous write (from `div_tvalid`) and read (from a `rsp` handshake) on the result FIFO are both honoured in the same cycle, including when the FIFO holds exactly 1 entry. Its count is unchanged.

## Test plan
- **Single request.** Dividend 24'h064000 (100.0), divisor 24'h004000 (4.0), tag 8'h5A → `rsp_result` 24'h019000 (25.0), `rsp_tag` 8'h5A, `rsp_div0` 0. `rsp_valid` rises at L+2 cycles after accept.
- **Divide by zero.**
  - Dividend 24'hFFD000 (−3.0), divisor 0 → `rsp_result` 24'h800000, `rsp_div0` 1.
  - Dividend 24'h001000, divisor 0 → `rsp_result` 24'h7FFFFF, `rsp_div0` 1.
- **Backpressure.** Hold `rsp_ready` = 0 and offer 20 requests with tags 0..19.
  - Exactly 16 are accepted, and `req_ready` goes low after the 16th.
  - `err_orphan` stays 0 and `pending` = 16.
  - Release `rsp_ready` → tags 0..15 appear in order, then 16..19 are accepted.
- **Full-boundary streaming.** At `pending` = 15, perform a simultaneous accept and response → `pending` stays 15. Stream 64 back-to-back requests with `rsp_ready` = 1 → one response per cycle, all matching a reference divide model.
- **Reset mid-operation.** Apply `rst` with 5 requests in flight → all outputs take their reset values the next cycle. The divider's stale `div_tvalid` then sets `err_orphan` = 1, and no `rsp_valid` results. A new request after reset completes correctly once the divider is drained.
